// File: rtl/spi_slave_if.sv
// SPI responder for all four CPOL/CPHA modes; bus oversampled on clk, MISO moves SYNC_STAGES+1 clk after a shift edge.
// TX side is a one-entry holding register (tx_ready = empty); RX has no backpressure, every rx_valid pulse must be taken.
module spi_slave_if #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DUMMY_BYTE  = 8'hFF,
  parameter int         CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  output logic             MISO,
  output logic             miso_oe,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_q;
  logic                   cs_q;
  logic                   sck_s;
  logic                   cs_s;
  logic                   mosi_s;

  logic [1:0] mode_r;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr;
  logic [7:0] rx_nxt;
  logic [7:0] tx_sr;
  logic [7:0] hold;
  logic       full;

  logic cpol;
  logic cpha;
  logic sck_edge;
  logic lead_edge;
  logic trail_edge;
  logic cs_fall;
  logic cs_rise;
  logic start;
  logic sample_edge;
  logic shift_edge;
  logic load;
  logic underrun_now;
  logic [7:0] load_byte;

  // CS idles high, so its chain resets to ones to avoid a false select after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_q     <= sck_s;
      cs_q      <= cs_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cpol       = mode_r[1];
  assign cpha       = mode_r[0];
  assign sck_edge   = sck_s ^ sck_q;
  assign lead_edge  = sck_edge && (sck_s != cpol);
  assign trail_edge = sck_edge && (sck_s == cpol);
  assign cs_fall    = cs_q && !cs_s;
  assign cs_rise    = !cs_q && cs_s;
  assign start      = (state == IDLE) && cs_fall;

  assign sample_edge = (state == ACTIVE) && !cs_rise && (cpha ? trail_edge : lead_edge);
  assign shift_edge  = (state == ACTIVE) && !cs_rise && (cpha ? lead_edge : trail_edge);

  // bit_cnt==0 on a shift edge marks a byte boundary in both phases: for CPHA=1 it is the
  // first leading edge of a byte, for CPHA=0 the first trailing edge after the 8th sample.
  assign load         = (start && !mode[0]) || (shift_edge && (bit_cnt == 3'd0));
  assign underrun_now = load && !full && !tx_valid;
  assign load_byte    = full ? hold : (tx_valid ? tx_data : DUMMY_BYTE);
  assign rx_nxt       = {rx_sr[6:0], mosi_s};
  assign tx_ready     = !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    miso_oe = 1'b0;
    MISO    = 1'b1;
    if (state == ACTIVE) begin
      busy    = 1'b1;
      miso_oe = 1'b1;
      MISO    = tx_sr[7];
    end
  end

  // A load always empties the holding register; a same-cycle tx_valid bypasses straight into tx_sr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold        <= 8'h00;
      full        <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= underrun_now;
      if (load) begin
        full <= 1'b0;
      end else if (tx_valid && !full) begin
        hold <= tx_data;
        full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r     <= 2'b00;
      bit_cnt    <= 3'd0;
      rx_sr      <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_sr      <= 8'hFF;
      byte_count <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (start) begin
        mode_r     <= mode;
        bit_cnt    <= 3'd0;
        byte_count <= '0;
        tx_sr      <= mode[0] ? 8'hFF : load_byte;
      end else if ((state == ACTIVE) && cs_rise) begin
        bit_cnt <= 3'd0;
        tx_sr   <= 8'hFF;
      end else begin
        if (sample_edge) begin
          rx_sr <= rx_nxt;
          if (bit_cnt == 3'd7) begin
            rx_data  <= rx_nxt;
            rx_valid <= 1'b1;
            bit_cnt  <= 3'd0;
            if (byte_count != '1) byte_count <= byte_count + CNT_W'(1);
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        if (shift_edge) begin
          tx_sr <= (bit_cnt == 3'd0) ? load_byte : {tx_sr[6:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI responder (slave) for the same 4-wire bus our SPI master drives: CS, SCK, MOSI, MISO.
- Oversamples the bus with the system clock and supports all four CPOL/CPHA modes.
- Deserialises MOSI into bytes for the fabric and serialises fabric-supplied bytes onto MISO.
- Sits between the external SPI pins and a byte-stream consumer/producer (typically a FIFO).

Parameters:
- SYNC_STAGES, 2, synchroniser depth for SCK/CS/MOSI (minimum 2).
- DUMMY_BYTE, 8'hFF, byte shifted out when no TX byte is available.
- CNT_W, 10, width of byte_count.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- mode  in  2  {CPOL,CPHA}. Latched at CS falling edge.
- SCK  in  1  bus clock from master.
- CS  in  1  chip select, active-low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- miso_oe  out  1  1 while selected; pad tri-state enable.
- tx_data  in  8  next byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse, rx_data new.
- tx_underrun  out  1  one-cycle pulse, DUMMY_BYTE was loaded.
- busy  out  1  transaction in progress (synced CS low).
- byte_count  out  CNT_W  bytes received in the current transaction.

Behaviour:
- Reset values: MISO=1, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, byte_count=0. The CS synchroniser resets to 1; the SCK and MOSI synchronisers reset to 0.
- Synchronisation and edge detection:
  - SCK, CS and MOSI each pass through SYNC_STAGES flops; edges are detected on the synced values.
  - Leading edge = SCK transition away from CPOL. Trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- Timing limits:
  - SCK must be ≤ clk/8 (12.5 MHz); faster SCK is out of spec and not checked.
  - MISO updates SYNC_STAGES+1 clk after the physical shift edge.
- State machine:
  - IDLE: CS synced high, miso_oe=0, MISO=1. On the synced CS falling edge: latch mode, clear bit_cnt and byte_count, busy=1, miso_oe=1.
    - CPHA=0: load tx_sr immediately, so MISO=bit7 before the first SCK edge. Go to ACTIVE.
    - CPHA=1: MISO=1 until the first shift edge. Go to ACTIVE.
  - ACTIVE, sample edge: rx_sr <= {rx_sr[6:0],MOSI}, bit_cnt++. When bit_cnt reaches 8:
    - rx_data <= completed byte; rx_valid pulses 1 cycle.
    - byte_count++, saturating at all-ones.
    - bit_cnt <= 0.
  - ACTIVE, shift edge:
    - If a byte boundary is pending, load tx_sr. For CPHA=0 the boundary is the first shift edge after the 8th sample; for CPHA=1 it is the first leading edge of each byte.
    - Otherwise tx_sr <<= 1.
    - MISO always follows tx_sr[7].
  - Synced CS rising edge in any state → IDLE:
    - Discard any partial byte; no rx_valid.
    - bit_cnt=0, busy=0, miso_oe=0, MISO=1. byte_count holds its value until the next CS fall.
- TX holding register (single entry):
  - tx_ready = !full. A cycle with tx_valid && tx_ready captures tx_data and sets full.
  - A load takes the holding byte and clears full.
  - If empty at load time and tx_valid=1 in the same cycle, tx_data bypasses into tx_sr and counts as accepted.
  - If empty with no tx_valid, DUMMY_BYTE is loaded and tx_underrun pulses.
  - For CPHA=0, a byte loaded after the last sample of a transaction is consumed even if the master deasserts CS.
- Overrun: rx has no backpressure. The consumer must accept each rx_valid pulse.
- Mode changes while CS is low are ignored until the next CS fall.
- Asynchronous reset mid-transaction: everything returns to reset values immediately. The holding register is emptied.

Test Plan:
- Mode 0, SCK=clk/10, holding=8'hA5, master sends 8'h3C → rx_data=8'h3C with one rx_valid pulse; master reads 8'hA5; byte_count=1; tx_ready=1 after the load.
- Modes 1, 2 and 3, each sending 8'h96 and receiving 8'h5A → correct bytes in both directions in every mode; bit order MSB first.
- Burst of 4 bytes (8'h53,8'h50,8'h49,8'h57), with the fabric refilling only the first 2 TX bytes → master reads 2 data bytes then 8'hFF,8'hFF; tx_underrun pulses twice; byte_count=4.
- CS deasserted after 5 SCK cycles of a byte → no rx_valid; busy=0; MISO=1; miso_oe=0. Next transaction receives a full byte correctly.
- Assert rst_n=0 mid-byte with the holding register full → all outputs at reset values within the same cycle; tx_ready=1 after release.
- tx_valid asserted in the same cycle as an empty-register load → tx_data appears on MISO; no tx_underrun.
